// File: rtl/clarvi_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit: one operation in flight, tagged response.
// Build option CLARVI_MDU_RADIX4_MUL_EN: multiplier retires two bits per cycle instead of one.
`timescale 1ns/1ps
module clarvi_mdu #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic             req_is32,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [XLEN-1:0]  req_rs2,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic [TAG_W-1:0] resp_tag,
   input  logic             flush,
   output logic             busy
);
   localparam int CW = $clog2(XLEN);
   localparam int PW = 2 * XLEN;
`ifdef CLARVI_MDU_RADIX4_MUL_EN
   localparam int MUL_STEP = 2;
`else
   localparam int MUL_STEP = 1;
`endif
   localparam logic [CW-1:0] MUL_LAST_W = CW'(32 / MUL_STEP - 1);
   localparam logic [CW-1:0] MUL_LAST_X = CW'(XLEN / MUL_STEP - 1);
   localparam logic [CW-1:0] DIV_LAST_W = CW'(31);
   localparam logic [CW-1:0] DIV_LAST_X = CW'(XLEN - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [2:0]       op;
   logic             is32;
   logic [TAG_W-1:0] tag;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [XLEN-1:0]  mplier;
   logic             mplier_signed;
   logic [XLEN-1:0]  rem;
   logic [XLEN-1:0]  quo;
   logic [XLEN-1:0]  dvsr;
   logic             neg_q;
   logic             neg_r;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic signed [31:0] s;
      s = v;
      return XLEN'(s);
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
      return XLEN'(v);
   endfunction

   // Request decode: K-bit operand fields extended to XLEN, plus the divide shortcuts.
   logic            is32_in;
   logic            a_signed;
   logic            b_signed;
   logic            is_div_signed;
   logic [XLEN-1:0] a_k;
   logic [XLEN-1:0] b_k;
   logic [XLEN-1:0] a_res;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] most_neg;
   logic [XLEN-1:0] direct_res;
   logic [XLEN-1:0] dividend_in;
   logic [PW-1:0]   mcand_in;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            div_ovf;

   always_comb begin
      is32_in       = req_is32 && (XLEN == 64);
      is_div_signed = req_op[2] && !req_op[0];
      a_signed      = req_op[2] ? !req_op[0] : (req_op[1:0] != 2'b11);
      b_signed      = req_op[2] ? !req_op[0] : !req_op[1];
      if (is32_in) begin
         a_k   = a_signed ? sext32(req_rs1[31:0]) : zext32(req_rs1[31:0]);
         b_k   = b_signed ? sext32(req_rs2[31:0]) : zext32(req_rs2[31:0]);
         a_res = sext32(req_rs1[31:0]);
         most_neg = sext32(32'h8000_0000);
      end else begin
         a_k   = req_rs1;
         b_k   = req_rs2;
         a_res = req_rs1;
         most_neg = {1'b1, {(XLEN-1){1'b0}}};
      end
      mcand_in    = a_signed ? PW'(signed'(a_k)) : PW'(a_k);
      a_neg       = is_div_signed && a_k[XLEN-1];
      b_neg       = is_div_signed && b_k[XLEN-1];
      a_mag       = a_neg ? -a_k : a_k;
      b_mag       = b_neg ? -b_k : b_k;
      dividend_in = is32_in ? (a_mag << (XLEN - 32)) : a_mag;
      div_zero    = (b_k == '0);
      div_ovf     = is_div_signed && (a_k == most_neg) && (b_k == '1);
      if (div_zero)
         direct_res = req_op[1] ? a_res : '1;
      else
         direct_res = req_op[1] ? '0 : a_res;
   end

   // Multiply step: shift-add, with the multiplier's top bit weighted negative when signed.
   logic            mul_last;
   logic [PW-1:0]   acc_next;
   logic [XLEN-1:0] mul_res;

   always_comb begin
      mul_last = (count == (is32 ? MUL_LAST_W : MUL_LAST_X));
      acc_next = acc;
      if (mplier[0])
         acc_next = (MUL_STEP == 1 && mplier_signed && mul_last) ? acc_next - mcand
                                                                 : acc_next + mcand;
`ifdef CLARVI_MDU_RADIX4_MUL_EN
      if (mplier[1])
         acc_next = (mplier_signed && mul_last) ? acc_next - (mcand << 1)
                                                : acc_next + (mcand << 1);
`endif
      if (op[1:0] == 2'b00)
         mul_res = is32 ? sext32(acc_next[31:0]) : acc_next[XLEN-1:0];
      else
         mul_res = is32 ? sext32(acc_next[63:32]) : acc_next[PW-1:XLEN];
   end

   // Restoring divide step on magnitudes; dividend is left-aligned so bit K-1 enters first.
   logic            div_last;
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_diff;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;
   logic [XLEN-1:0] q_signed;
   logic [XLEN-1:0] r_signed;
   logic [XLEN-1:0] div_res;

   always_comb begin
      div_last  = (count == (is32 ? DIV_LAST_W : DIV_LAST_X));
      div_shift = {rem, quo[XLEN-1]};
      div_diff  = div_shift - {1'b0, dvsr};
      rem_next  = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      quo_next  = {quo[XLEN-2:0], !div_diff[XLEN]};
      q_signed  = neg_q ? -quo_next : quo_next;
      r_signed  = neg_r ? -rem_next : rem_next;
      if (op[1])
         div_res = is32 ? sext32(r_signed[31:0]) : r_signed;
      else
         div_res = is32 ? sext32(q_signed[31:0]) : q_signed;
   end

   assign req_ready = (state == IDLE) && !flush;
   assign busy      = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         count         <= '0;
         op            <= '0;
         is32          <= 1'b0;
         tag           <= '0;
         acc           <= '0;
         mcand         <= '0;
         mplier        <= '0;
         mplier_signed <= 1'b0;
         rem           <= '0;
         quo           <= '0;
         dvsr          <= '0;
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
         resp_valid    <= 1'b0;
         resp_result   <= '0;
         resp_tag      <= '0;
      end else if (flush) begin
         state      <= IDLE;
         count      <= '0;
         resp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op    <= req_op;
                  is32  <= is32_in;
                  tag   <= req_tag;
                  count <= '0;
                  if (!req_op[2]) begin
                     acc           <= '0;
                     mcand         <= mcand_in;
                     mplier        <= b_k;
                     mplier_signed <= b_signed;
                     state         <= MUL;
                  end else if (div_zero || div_ovf) begin
                     resp_result <= direct_res;
                     resp_tag    <= req_tag;
                     resp_valid  <= 1'b1;
                     state       <= DONE;
                  end else begin
                     rem   <= '0;
                     quo   <= dividend_in;
                     dvsr  <= b_mag;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                     state <= DIV;
                  end
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << MUL_STEP;
               mplier <= mplier >> MUL_STEP;
               if (mul_last) begin
                  count       <= '0;
                  resp_result <= mul_res;
                  resp_tag    <= tag;
                  resp_valid  <= 1'b1;
                  state       <= DONE;
               end else begin
                  count <= count + CW'(1);
               end
            end
            DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               if (div_last) begin
                  count       <= '0;
                  resp_result <= div_res;
                  resp_tag    <= tag;
                  resp_valid  <= 1'b1;
                  state       <= DONE;
               end else begin
                  count <= count + CW'(1);
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clarvi_mdu.sv
// Directed self-checking bench for clarvi_mdu (XLEN=64): arithmetic vectors, latency,
// backpressure, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_clarvi_mdu;
   localparam int XLEN  = 64;
   localparam int TAG_W = 5;
`ifdef CLARVI_MDU_RADIX4_MUL_EN
   localparam int MSTEP = 2;
`else
   localparam int MSTEP = 1;
`endif
   localparam int LAT_MUL   = 64 / MSTEP + 1;
   localparam int LAT_MULW  = 32 / MSTEP + 1;
   localparam int LAT_DIV   = 65;
   localparam int LAT_DIVW  = 33;
   localparam int LAT_DIRECT = 1;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [2:0]       req_op = '0;
   logic             req_is32 = 1'b0;
   logic [XLEN-1:0]  req_rs1 = '0;
   logic [XLEN-1:0]  req_rs2 = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [XLEN-1:0]  resp_result;
   logic [TAG_W-1:0] resp_tag;
   logic             flush = 1'b0;
   logic             busy;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   clarvi_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_is32    (req_is32),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .req_tag     (req_tag),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_tag    (resp_tag),
      .flush       (flush),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t);
      @(negedge clock);
      req_valid = 1'b1;
      req_op    = op;
      req_is32  = w;
      req_rs1   = a;
      req_rs2   = b;
      req_tag   = t;
      @(posedge clock);
      #1 req_valid = 1'b0;
   endtask

   // Latency counts edges including the accept edge; bounded so a dead DUT cannot hang.
   task automatic wait_resp(output int lat);
      lat = 1;
      @(negedge clock);
      while (!resp_valid && lat < 300) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic w,
                      input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                      input logic [63:0] exp, input int exp_lat);
      int lat;
      issue(op, w, a, b, t);
      wait_resp(lat);
      check({name, " valid"}, 64'(resp_valid), 64'd1);
      check({name, " result"}, resp_result, exp);
      check({name, " tag"}, 64'(resp_tag), 64'(t));
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      $display("[TB] %s tag=%0d result=%h latency=%0d", name, resp_tag, resp_result, lat);
      resp_ready = 1'b1;
      @(posedge clock);
      #1 resp_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int stray;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset resp_valid", 64'(resp_valid), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset resp_result", resp_result, 64'd0);
      check("reset resp_tag", 64'(resp_tag), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("req_ready after reset", 64'(req_ready), 64'd1);

      // Arithmetic vectors
      run("MULH minneg*-1", OP_MULH, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1,
          64'h0000_0000_0000_0000, LAT_MUL);
      run("MUL minneg*-1", OP_MUL, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
          64'h8000_0000_0000_0000, LAT_MUL);
      run("MULH 2^62*4", OP_MULH, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 5'd3,
          64'd1, LAT_MUL);
      run("MULHU max*max", OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4,
          64'hFFFF_FFFF_FFFF_FFFE, LAT_MUL);
      run("MULHSU -1*2", OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5,
          64'hFFFF_FFFF_FFFF_FFFF, LAT_MUL);
      run("MULHSU 1*2^63", OP_MULHSU, 1'b0, 64'd1, 64'h8000_0000_0000_0000, 5'd6,
          64'd0, LAT_MUL);
      run("MULW", OP_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd7,
          64'hFFFF_FFFF_FFFF_FFFE, LAT_MULW);
      run("DIV -7/2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8,
          64'hFFFF_FFFF_FFFF_FFFD, LAT_DIV);
      run("REM -7%2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9,
          64'hFFFF_FFFF_FFFF_FFFF, LAT_DIV);
      run("REMU 100%7", OP_REMU, 1'b0, 64'd100, 64'd7, 5'd10,
          64'd2, LAT_DIV);
      run("DIVU 7/0", OP_DIVU, 1'b0, 64'd7, 64'd0, 5'd11,
          64'hFFFF_FFFF_FFFF_FFFF, LAT_DIRECT);
      run("REM -5%0", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd12,
          64'hFFFF_FFFF_FFFF_FFFB, LAT_DIRECT);
      run("DIVW overflow", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd13,
          64'hFFFF_FFFF_8000_0000, LAT_DIRECT);
      run("REMW overflow", OP_REM, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd14,
          64'd0, LAT_DIRECT);
      run("DIVUW max/1", OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 5'd15,
          64'hFFFF_FFFF_FFFF_FFFF, LAT_DIVW);
      run("REMW -7%2", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd16,
          64'hFFFF_FFFF_FFFF_FFFF, LAT_DIVW);

      // Flush mid-multiply with a competing request in the same cycle
      issue(OP_MUL, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd3);
      repeat (19) @(posedge clock);
      @(negedge clock);
      check("busy before flush", 64'(busy), 64'd1);
      flush     = 1'b1;
      req_valid = 1'b1;
      req_op    = OP_DIVU;
      req_is32  = 1'b0;
      req_rs1   = 64'd7;
      req_rs2   = 64'd0;
      req_tag   = 5'd7;
      #1 check("req_ready during flush", 64'(req_ready), 64'd0);
      @(posedge clock);
      #1 begin
         flush     = 1'b0;
         req_valid = 1'b0;
      end
      @(negedge clock);
      check("flush resp_valid", 64'(resp_valid), 64'd0);
      check("flush busy", 64'(busy), 64'd0);
      check("flush req_ready", 64'(req_ready), 64'd1);
      stray = 0;
      repeat (80) begin
         @(negedge clock);
         if (resp_valid) stray++;
      end
      check("no response after flush", 64'(stray), 64'd0);
      run("MULHU 3*5 after flush", OP_MULHU, 1'b0, 64'd3, 64'd5, 5'd12, 64'd0, LAT_MUL);

      // Reset mid-divide; leave a nonzero result in the output register first
      run("REM -7%2 pre-reset", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd21,
          64'hFFFF_FFFF_FFFF_FFFF, LAT_DIV);
      issue(OP_DIV, 1'b0, 64'd1000, 64'd7, 5'd20);
      repeat (10) @(posedge clock);
      @(negedge clock);
      check("busy before reset", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("async reset resp_valid", 64'(resp_valid), 64'd0);
      check("async reset busy", 64'(busy), 64'd0);
      check("async reset resp_result", resp_result, 64'd0);
      check("async reset resp_tag", 64'(resp_tag), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("req_ready after mid-op reset", 64'(req_ready), 64'd1);
      stray = 0;
      repeat (100) begin
         @(negedge clock);
         if (resp_valid) stray++;
      end
      check("no stale response after reset", 64'(stray), 64'd0);

      // Backpressure: hold resp_ready low for 10 cycles
      issue(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd9);
      wait_resp(lat);
      check("stall latency", 64'(lat), 64'(LAT_DIV));
      check("stall result", resp_result, 64'd14);
      $display("[TB] DIVU 100/7 tag=%0d result=%h latency=%0d", resp_tag, resp_result, lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         @(negedge clock);
         check($sformatf("stall valid %0d", i), 64'(resp_valid), 64'd1);
         check($sformatf("stall result %0d", i), resp_result, 64'd14);
         check($sformatf("stall tag %0d", i), 64'(resp_tag), 64'd9);
         check($sformatf("stall req_ready %0d", i), 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_op     = OP_DIVU;
      req_rs1    = 64'd7;
      req_rs2    = 64'd0;
      req_tag    = 5'd4;
      @(posedge clock);
      #1 begin
         resp_ready = 1'b0;
         req_valid  = 1'b0;
      end
      @(negedge clock);
      check("release resp_valid", 64'(resp_valid), 64'd0);
      check("release busy (no accept)", 64'(busy), 64'd0);
      check("release req_ready", 64'(req_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
